spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
// - Command sequencer that sits between the SPI slave byte interface (RX_DV/RX_Byte/TX_DV/TX_Byte) and a register bank.
// - Parses the first byte of each CS_n-framed transaction as a command: bit7 = read (1) or write (0), bits[ADDR_W-1:0] = start address.
// - Streams burst writes and reads with address auto-increment, and loads MISO data back into the slave.
// PARAMETERS
// - ADDR_W       7      register address width (ADDR_W <= 7); address comes from cmd[ADDR_W-1:0]
// - STATUS_BYTE  8'hA5  byte preloaded to TX while idle, so it is shifted out during the command byte
// - SYNC_STAGES  2      flops in the i_SPI_CS_n synchronizer (>= 2)
// PORTS
// - i_Clk          in   1       system clock (same domain as SPI slave i_Clk)
// - i_Rst          in   1       asynchronous reset, active-high
// - i_SPI_CS_n     in   1       raw SPI chip select (async), active low
// - i_RX_DV        in   1       1-cycle pulse: byte received from the SPI slave
// - i_RX_Byte      in   8       received byte, valid when i_RX_DV=1
// - o_TX_DV        out  1       1-cycle pulse: load o_TX_Byte into the SPI slave
// - o_TX_Byte      out  8       byte for the slave to serialize on MISO
// - o_Reg_Wr_En    out  1       1-cycle register write strobe
// - o_Reg_Rd_En    out  1       1-cycle register read strobe
// - o_Reg_Addr     out  ADDR_W  register address for the current strobe
// - o_Reg_Wr_Data  out  8       write data, valid with o_Reg_Wr_En
// - i_Reg_Rd_Data  in   8       read data, valid exactly 1 cycle after o_Reg_Rd_En
// - o_Busy         out  1       1 while not in S_IDLE
// BEHAVIOUR
// - Reset: state S_IDLE; all outputs 0; o_TX_Byte = 8'h00; address counter 0; synchronizer flops 1 (CS inactive).
// - CS synchronizer: cs_s is i_SPI_CS_n after SYNC_STAGES flops. Fall = cs_s_d=1 & cs_s=0. Rise = cs_s_d=0 & cs_s=1.
// - S_IDLE:
//   - On the first cycle after reset, and on every entry to S_IDLE, o_TX_DV pulses with o_TX_Byte = STATUS_BYTE.
//   - A CS fall moves to S_CMD. i_RX_DV is ignored in S_IDLE.
// - S_CMD, on i_RX_DV:
//   - addr <= i_RX_Byte[ADDR_W-1:0].
//   - If i_RX_Byte[7]=1: pulse o_Reg_Rd_En with o_Reg_Addr = that address, next state S_RD_WAIT.
//   - Otherwise: next state S_WR.
// - S_WR, on each i_RX_DV:
//   - Pulse o_Reg_Wr_En with o_Reg_Addr = addr and o_Reg_Wr_Data = i_RX_Byte.
//   - addr <= addr + 1, modulo 2^ADDR_W (wraps from all-ones to 0).
// - S_RD_WAIT (exactly 1 cycle):
//   - o_TX_DV pulses with o_TX_Byte = i_Reg_Rd_Data.
//   - addr <= addr + 1 (same wrap rule). Next state S_RD.
// - S_RD, on each i_RX_DV (dummy byte from master, value ignored):
//   - Pulse o_Reg_Rd_En at addr, next state S_RD_WAIT.
// - Read latency: i_RX_DV -> o_TX_DV is 2 cycles.
//   - The slave must be loaded before the next byte's MSB is shifted; the i_Clk >= 4x SPI clock ratio guarantees this.
//   - Read byte N is clocked out during the master's byte N+1.
// - Strobes are registered and mutually exclusive: at most one of Wr_En/Rd_En/TX_DV per cycle, except TX_DV alongside S_IDLE entry.
// - CS rise in any non-idle state: go to S_IDLE next cycle (abort). No further register strobes are issued, and an in-flight read's TX load is dropped.
// - i_RX_DV in the same cycle as a CS rise: the byte is processed first (write or read strobe), then the state goes to S_IDLE.
// - CS fall while already non-idle (glitch re-frame): ignored.
// - i_Rst mid-transaction: immediate return to the reset state. No partial strobe may be visible after reset asserts.
// STRUCTURE
// - Package spi_reg_pkg: state encoding (S_IDLE, S_CMD, S_WR, S_RD, S_RD_WAIT), CMD_RD_BIT = 7.
// - Sub-module sync_ff (parameterized depth, async reset to 1) for i_SPI_CS_n.
// - Remainder is a single FSM plus an address counter in spi_reg_ctrl.
// TESTING
// - Reset release: o_TX_DV pulses once with o_TX_Byte = 8'hA5; all other outputs 0; o_Busy = 0.
// - CS low, then RX bytes 8'h05, 8'h11, 8'h22, CS high:
//   - Wr_En at addr 5 with 8'h11, then at addr 6 with 8'h22.
//   - Busy drops after CS rise; STATUS_BYTE reloaded.
// - CS low, then RX 8'h83 and two dummy bytes, with bank holding [3]=8'h3C and [4]=8'h4D:
//   - Rd_En at addr 3 and TX_DV 8'h3C 2 cycles after the first RX_DV.
//   - Then Rd_En at addr 4 and TX_DV 8'h4D.
// - Write burst 8'h7E, then data bytes 8'hAA, 8'hBB, 8'hCC:
//   - Writes land at addr 7E, 7F, 00 (wrap).
// - CS rise in the same cycle as a write byte's RX_DV: that write is issued; the next RX_DV (no CS fall) produces no strobe.
// - i_Rst asserted in S_RD_WAIT: no o_TX_DV from the pending read; state S_IDLE; outputs 0.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types for the SPI command sequencer: FSM state encoding and command fields.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR,
    S_RD,
    S_RD_WAIT
  } state_t;

  localparam int unsigned CMD_RD_BIT = 7;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single async level; resets to 1 (inactive chip select).
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_D,
  output logic o_Q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) ff <= '1;
    else       ff <= {ff[STAGES-2:0], i_D};
  end

  assign o_Q = ff[STAGES-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command sequencer between an SPI slave byte interface and a register bank:
// first byte of each CS_n frame is {rd, addr}; following bytes stream with address auto-increment.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_SPI_CS_n,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  output logic              o_Reg_Wr_En,
  output logic              o_Reg_Rd_En,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic [7:0]        o_Reg_Wr_Data,
  input  logic [7:0]        i_Reg_Rd_Data,
  output logic              o_Busy
);

  logic cs_s, cs_s_d, cs_fall, cs_rise;

  sync_ff #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_D   (i_SPI_CS_n),
    .o_Q   (cs_s)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) cs_s_d <= 1'b1;
    else       cs_s_d <= cs_s;
  end

  assign cs_fall = cs_s_d & ~cs_s;
  assign cs_rise = ~cs_s_d & cs_s;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              boot;
  logic              tx_dv_nxt, wr_en_nxt, rd_en_nxt, busy_nxt;
  logic [7:0]        tx_byte_nxt, wr_data_nxt;
  logic [ADDR_W-1:0] reg_addr_nxt;

  // State, address counter and registered outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      boot          <= 1'b1;
      o_TX_DV       <= 1'b0;
      o_TX_Byte     <= 8'h00;
      o_Reg_Wr_En   <= 1'b0;
      o_Reg_Rd_En   <= 1'b0;
      o_Reg_Addr    <= '0;
      o_Reg_Wr_Data <= 8'h00;
      o_Busy        <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr          <= addr_nxt;
      boot          <= 1'b0;
      o_TX_DV       <= tx_dv_nxt;
      o_TX_Byte     <= tx_byte_nxt;
      o_Reg_Wr_En   <= wr_en_nxt;
      o_Reg_Rd_En   <= rd_en_nxt;
      o_Reg_Addr    <= reg_addr_nxt;
      o_Reg_Wr_Data <= wr_data_nxt;
      o_Busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    tx_dv_nxt    = 1'b0;
    tx_byte_nxt  = o_TX_Byte;
    wr_en_nxt    = 1'b0;
    rd_en_nxt    = 1'b0;
    reg_addr_nxt = o_Reg_Addr;
    wr_data_nxt  = o_Reg_Wr_Data;

    case (state)
      S_IDLE: begin
        if (cs_fall) state_nxt = S_CMD;
      end
      S_CMD: begin
        if (i_RX_DV) begin
          addr_nxt = i_RX_Byte[ADDR_W-1:0];
          if (i_RX_Byte[CMD_RD_BIT]) begin
            rd_en_nxt    = 1'b1;
            reg_addr_nxt = i_RX_Byte[ADDR_W-1:0];
            state_nxt    = S_RD_WAIT;
          end else begin
            state_nxt = S_WR;
          end
        end
      end
      S_WR: begin
        if (i_RX_DV) begin
          wr_en_nxt    = 1'b1;
          reg_addr_nxt = addr;
          wr_data_nxt  = i_RX_Byte;
          addr_nxt     = addr + ADDR_W'(1);
        end
      end
      S_RD_WAIT: begin
        tx_dv_nxt   = 1'b1;
        tx_byte_nxt = i_Reg_Rd_Data;
        addr_nxt    = addr + ADDR_W'(1);
        state_nxt   = S_RD;
      end
      S_RD: begin
        if (i_RX_DV) begin
          rd_en_nxt    = 1'b1;
          reg_addr_nxt = addr;
          state_nxt    = S_RD_WAIT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Frame end aborts after the current byte; the status load replaces any pending read data
    if (state != S_IDLE && cs_rise) state_nxt = S_IDLE;
    if (boot || (state != S_IDLE && state_nxt == S_IDLE)) begin
      tx_dv_nxt   = 1'b1;
      tx_byte_nxt = STATUS_BYTE;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames plus random bursts against a register-bank model.
module tb_spi_reg_ctrl;

  localparam logic [7:0] STATUS = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       wr_en, rd_en;
  logic [6:0] reg_addr;
  logic [7:0] wr_data, rd_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int excl_err = 0;

  logic [7:0]  bank [128];
  logic [7:0]  rd_hold;
  logic [7:0]  ref_bank [128];
  logic [14:0] wr_q[$];
  logic [6:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  txn[$];

  always #5 clk = ~clk;

  spi_reg_ctrl dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_SPI_CS_n    (cs_n),
    .i_RX_DV       (rx_dv),
    .i_RX_Byte     (rx_byte),
    .o_TX_DV       (tx_dv),
    .o_TX_Byte     (tx_byte),
    .o_Reg_Wr_En   (wr_en),
    .o_Reg_Rd_En   (rd_en),
    .o_Reg_Addr    (reg_addr),
    .o_Reg_Wr_Data (wr_data),
    .i_Reg_Rd_Data (rd_data),
    .o_Busy        (busy)
  );

  // Register bank device: seeded contents on reset, read data offered while the strobe is up and held after
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) bank[i] <= 8'(i * 37 + 5);
    end else if (wr_en) begin
      bank[reg_addr] <= wr_data;
    end
  end

  always @(posedge clk) if (rd_en) rd_hold <= bank[reg_addr];
  assign rd_data = rd_en ? bank[reg_addr] : rd_hold;

  // Event monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) wr_q.push_back({reg_addr, wr_data});
      if (rd_en) rd_q.push_back(reg_addr);
      if (tx_dv) tx_q.push_back(tx_byte);
      if ((wr_en && rd_en) || (rd_en && tx_dv)) excl_err++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_init();
    for (int i = 0; i < 128; i++) ref_bank[i] = 8'(i * 37 + 5);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(posedge clk); #1 rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1 rx_dv = 1'b0; rx_byte = 8'($urandom);
  endtask

  // One CS-framed transaction from txn[]; expectations come from the command rules and ref_bank
  task automatic do_txn(input string tag);
    int wb, rb, tb, n, a, nw, nr;
    logic [7:0] cmd;
    wb = wr_q.size(); rb = rd_q.size(); tb = tx_q.size();
    n = txn.size(); cmd = txn[0]; a = int'(cmd[6:0]); nw = 0; nr = 0;
    cs_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk({tag, " busy_in_frame"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      pulse_rx(txn[i]);
      if (cmd[7]) begin
        chk({tag, " rd_en"}, 32'(rd_en), 32'd1);
        chk({tag, " rd_addr"}, 32'(reg_addr), 32'((a + i) % 128));
        @(posedge clk); #1;
        chk({tag, " tx_dv"}, 32'(tx_dv), 32'd1);
        chk({tag, " tx_byte"}, 32'(tx_byte), 32'(ref_bank[(a + i) % 128]));
        nr++;
      end else if (i > 0) begin
        chk({tag, " wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, " wr_addr"}, 32'(reg_addr), 32'((a + i - 1) % 128));
        chk({tag, " wr_data"}, 32'(wr_data), 32'(txn[i]));
        ref_bank[(a + i - 1) % 128] = txn[i];
        nw++;
      end else begin
        chk({tag, " cmd_quiet"}, 32'(wr_en | rd_en | tx_dv), 32'd0);
      end
      repeat (5) @(posedge clk);
    end
    @(posedge clk); #1 cs_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " wr_count"}, 32'(wr_q.size() - wb), 32'(nw));
    chk({tag, " rd_count"}, 32'(rd_q.size() - rb), 32'(nr));
    chk({tag, " tx_count"}, 32'(tx_q.size() - tb), 32'(nr + 1));
    if (tx_q.size() > 0) chk({tag, " status_reload"}, 32'(tx_q[tx_q.size() - 1]), 32'(STATUS));
  endtask

  initial begin
    int wb;
    rst = 1'b1; cs_n = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    ref_init();
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx_dv", 32'(tx_dv), 32'd0);
    chk("rst tx_byte", 32'(tx_byte), 32'd0);
    chk("rst strobes", 32'(wr_en | rd_en), 32'd0);
    chk("rst addr_data", 32'({reg_addr, wr_data}), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("boot tx_dv", 32'(tx_dv), 32'd1);
    chk("boot tx_byte", 32'(tx_byte), 32'(STATUS));
    chk("boot quiet", 32'(wr_en | rd_en | busy), 32'd0);
    @(posedge clk); #1;
    chk("boot single", 32'(tx_dv), 32'd0);

    txn = '{8'h05, 8'h11, 8'h22};                 do_txn("wr05");
    txn = '{8'h03, 8'h3C, 8'h4D};                 do_txn("wr03");
    txn = '{8'h83, 8'h00, 8'hFF};                 do_txn("rd83");
    txn = '{8'h7E, 8'hAA, 8'hBB, 8'hCC};          do_txn("wrap");
    chk("wrap bank00", 32'(bank[0]), 32'h0000_00CC);

    // CS rise coincident with a write byte: byte is written, the frame then ends
    wb = wr_q.size();
    cs_n = 1'b0;
    repeat (5) @(posedge clk);
    pulse_rx(8'h10);
    pulse_rx(8'h55);
    repeat (3) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rx_dv = 1'b1; rx_byte = 8'h66;
    @(posedge clk); #1 rx_dv = 1'b0;
    chk("edge wr_en", 32'(wr_en), 32'd1);
    chk("edge wr_addr", 32'(reg_addr), 32'h11);
    chk("edge wr_data", 32'(wr_data), 32'h66);
    chk("edge status", 32'({tx_dv, tx_byte}), 32'({1'b1, STATUS}));
    chk("edge busy", 32'(busy), 32'd0);
    ref_bank[16] = 8'h55; ref_bank[17] = 8'h66;
    repeat (3) @(posedge clk);
    pulse_rx(8'h77);
    chk("post_abort quiet", 32'(wr_en | rd_en | tx_dv), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("edge wr_count", 32'(wr_q.size() - wb), 32'd2);

    // Random bursts
    for (int t = 0; t < 16; t++) begin
      int len;
      len = int'($urandom_range(1, 5));
      txn = {};
      txn.push_back(8'($urandom));
      for (int k = 0; k < len; k++) txn.push_back(8'($urandom));
      do_txn($sformatf("rand%0d", t));
    end
    txn = '{8'h93, 8'h00, 8'h00};                 do_txn("rd_after");
    chk("exclusive strobes", 32'(excl_err), 32'd0);

    // Reset while a read is waiting on its TX load
    cs_n = 1'b0;
    repeat (5) @(posedge clk);
    pulse_rx(8'h90);
    chk("rstmid rd_en", 32'(rd_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid outs", 32'({tx_dv, wr_en, rd_en, busy}), 32'd0);
    chk("rstmid tx_byte", 32'(tx_byte), 32'd0);
    @(posedge clk); #1;
    chk("rstmid no_tx", 32'(tx_dv), 32'd0);
    chk("rstmid addr", 32'(reg_addr), 32'd0);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid boot", 32'({tx_dv, tx_byte}), 32'({1'b1, STATUS}));
    chk("rstmid idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
